// File: rtl/seq_emitter_pkg.sv
// Shared types for the serial sequence emitter.
// State encoding and bit-counter sizing.
package seq_emitter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_e;

   // Default pattern width and its bit-counter width (includes parity slot).
   localparam int unsigned SEQ_SIZE_DFLT = 4;
   localparam int unsigned BITCNT_W = $clog2(SEQ_SIZE_DFLT + 1);

   // Bit-counter width for an arbitrary pattern width (covers parity slot).
   function automatic int unsigned bitcnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/piso_shiftreg.sv
// Loadable parallel-in serial-out register, MSB out first.
// Serial input fills the LSB, so feeding ser_o back rotates the word.
module piso_shiftreg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_en_i,
   input  logic             ser_i,
   input  logic [WIDTH-1:0] par_i,
   output logic             ser_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Load has priority over shift; shifting moves toward the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= par_i;
      end else if (shift_en_i) begin
         data_q <= {data_q[WIDTH-2:0], ser_i};
      end
   end

   assign ser_o = data_q[WIDTH-1];
   assign q_o   = data_q;

endmodule

// File: rtl/sequence_emitter.sv
// Serial pattern emitter: valid/ready load, MSB-first shift-out, repeats.
// Optional even-parity bit per frame when SEQ_EMITTER_PARITY_EN is defined.
module sequence_emitter
   import seq_emitter_pkg::*;
#(
   parameter int unsigned SEQUENCE_SIZE = 4,
   parameter int unsigned REPEAT_W      = 4,
   parameter logic        IDLE_LEVEL    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [SEQUENCE_SIZE-1:0] bit_sequence,
   input  logic [REPEAT_W-1:0]      repeat_count,
   output logic                     serial_out,
   output logic                     bit_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned CNT_W = bitcnt_w(SEQUENCE_SIZE);
`ifdef SEQ_EMITTER_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(SEQUENCE_SIZE - 1);
   localparam logic [CNT_W-1:0] PAR_SLOT  = CNT_W'(SEQUENCE_SIZE);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         bitcnt_q, bitcnt_d;
   logic [REPEAT_W-1:0]      frame_q, frame_d;
   logic                     serial_q, serial_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     load;
   logic                     shift;
   logic                     pat_msb;
   logic [SEQUENCE_SIZE-1:0] pat_q;

   // The PISO rotates, so the pattern is intact at each frame boundary.
   // Its MSB always holds the bit currently on serial_out.
   piso_shiftreg #(
      .WIDTH(SEQUENCE_SIZE)
   ) u_piso (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .shift_en_i(shift),
      .ser_i     (pat_msb),
      .par_i     (bit_sequence),
      .ser_o     (pat_msb),
      .q_o       (pat_q)
   );

   // Next state and next registered outputs (the bit shown next cycle).
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      frame_d  = frame_q;
      serial_d = IDLE_LEVEL;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               load     = 1'b1;
               frame_d  = repeat_count;
               bitcnt_d = '0;
               serial_d = bit_sequence[SEQUENCE_SIZE-1];
               valid_d  = 1'b1;
               busy_d   = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            shift   = (bitcnt_q <= LAST_DATA);
            if (bitcnt_q < LAST_DATA) begin
               bitcnt_d = bitcnt_q + CNT_W'(1);
               serial_d = pat_q[SEQUENCE_SIZE-2];
            end else if (PAR_EN && (bitcnt_q == LAST_DATA)) begin
               bitcnt_d = PAR_SLOT;
               serial_d = ^pat_q;
            end else if (frame_q != '0) begin
               // Rotation restored the pattern; next frame starts gap-free.
               frame_d  = frame_q - REPEAT_W'(1);
               bitcnt_d = '0;
               serial_d = PAR_EN ? pat_q[SEQUENCE_SIZE-1]
                                 : pat_q[SEQUENCE_SIZE-2];
            end else begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         frame_q  <= '0;
         serial_q <= IDLE_LEVEL;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         frame_q  <= frame_d;
         serial_q <= serial_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign serial_out  = serial_q;
   assign bit_valid   = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_sequence_emitter.sv
// Directed bench for sequence_emitter (4-bit pattern, 4-bit repeat).
// Expectations follow SEQ_EMITTER_PARITY_EN when it is defined.
module tb_sequence_emitter;

   localparam int N = 4;
`ifdef SEQ_EMITTER_PARITY_EN
   localparam int LEN = N + 1;
`else
   localparam int LEN = N;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_valid = 1'b0;
   logic       start_ready;
   logic [3:0] bit_sequence = '0;
   logic [3:0] repeat_count = '0;
   logic       serial_out;
   logic       bit_valid;
   logic       busy;
   logic       done;

   int n_chk  = 0;
   int n_pass = 0;

   sequence_emitter #(
      .SEQUENCE_SIZE(4),
      .REPEAT_W     (4),
      .IDLE_LEVEL   (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .bit_sequence(bit_sequence),
      .repeat_count(repeat_count),
      .serial_out  (serial_out),
      .bit_valid   (bit_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_ser"}, serial_out, 0);
      check({tag, "_bv"}, bit_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rdy"}, start_ready, 1);
   endtask

   // Issue one request and compare the bit stream with a hand-built vector.
   task automatic run_req(input string tag, input logic [3:0] pat,
                          input logic [3:0] rc, input logic [63:0] exp,
                          input int nbits);
      check({tag, "_rdy0"}, start_ready, 1);
      start_valid  = 1'b1;
      bit_sequence = pat;
      repeat_count = rc;
      tick();
      start_valid  = 1'b0;
      bit_sequence = ~pat;
      repeat_count = 4'hF;
      for (int i = 0; i < nbits; i++) begin
         check({tag, "_bit"}, serial_out, exp[nbits-1-i]);
         check({tag, "_bv"}, bit_valid, 1);
         check({tag, "_nd"}, done, 0);
         tick();
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_dbv"}, bit_valid, 0);
      check({tag, "_dbusy"}, busy, 1);
      check({tag, "_dser"}, serial_out, 0);
      tick();
      chk_idle({tag, "_end"});
   endtask

   initial begin
      logic [3:0] rx;
      int         cnt;
      logic       seen;
      #12;
      chk_idle("rst");
      rst = 1'b0;
      tick();
      chk_idle("post_rst");

`ifdef SEQ_EMITTER_PARITY_EN
      run_req("t1011", 4'b1011, 4'd0, 64'b10111, 5);
      run_req("t0110", 4'b0110, 4'd2, 64'b011000110001100, 15);
      run_req("tpar", 4'b1011, 4'd1, 64'b1011110111, 10);
`else
      run_req("t1011", 4'b1011, 4'd0, 64'b1011, 4);
      run_req("t0110", 4'b0110, 4'd2, 64'b011001100110, 12);
      run_req("trep1", 4'b1011, 4'd1, 64'b10111011, 8);
`endif

      // Held request with a new pattern during an active frame.
      start_valid  = 1'b1;
      bit_sequence = 4'b1000;
      repeat_count = 4'd0;
      tick();
      bit_sequence = 4'b1111;
      for (int i = 0; i < LEN; i++) begin
         check("hold_bit", serial_out, (i < N) ? (i == 0) : 1);
         check("hold_rdy", start_ready, 0);
         tick();
      end
      check("hold_done", done, 1);
      check("hold_drdy", start_ready, 0);
      tick();
      check("hold_gap_bv", bit_valid, 0);
      check("hold_gap_rdy", start_ready, 1);
      tick();
      start_valid = 1'b0;
      for (int i = 0; i < LEN; i++) begin
         check("hold2_bit", serial_out, (i < N) ? 1 : 0);
         check("hold2_bv", bit_valid, 1);
         tick();
      end
      check("hold2_done", done, 1);
      tick();

      // Asynchronous reset during the second bit.
      start_valid  = 1'b1;
      bit_sequence = 4'b1010;
      tick();
      start_valid = 1'b0;
      tick();
      check("ab_bv_pre", bit_valid, 1);
      rst = 1'b1;
      #1;
      chk_idle("ab_async");
      tick();
      tick();
      check("ab_nodone", done, 0);
      rst = 1'b0;
      tick();
      chk_idle("ab_rel");
`ifdef SEQ_EMITTER_PARITY_EN
      run_req("ab_new", 4'b1010, 4'd0, 64'b10100, 5);
`else
      run_req("ab_new", 4'b1010, 4'd0, 64'b1010, 4);
`endif

      // Loopback receiver: match only after every 4th pattern bit.
      start_valid  = 1'b1;
      bit_sequence = 4'b1101;
      repeat_count = 4'd3;
      tick();
      start_valid = 1'b0;
      rx  = '0;
      cnt = 0;
      for (int i = 0; i < 4 * LEN; i++) begin
         check("lb_bv", bit_valid, 1);
         if ((i % LEN) < N) begin
            rx = {rx[2:0], serial_out};
            cnt++;
            check("lb_match", rx == 4'b1101, (cnt % 4) == 0);
         end
         tick();
      end
      check("lb_done", done, 1);
      tick();

      // All-ones repeat count: 16 frames, no counter wrap.
      start_valid  = 1'b1;
      bit_sequence = 4'b1001;
      repeat_count = 4'hF;
      tick();
      start_valid = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (done) seen = 1'b1;
         else begin
            if (bit_valid) cnt++;
            tick();
         end
      end
      check("ones_done", seen, 1);
      check("ones_bits", cnt, 16 * LEN);
      tick();
      chk_idle("ones_end");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
